// File: rtl/alu_arbiter_if.sv
// alu_arbiter shared types and requester/arbiter handshake bundle.
// Requesters drive the master side, the arbiter sits on the slave side.
package alu_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  func_t;

  localparam func_t F_AND = 4'b0000;
  localparam func_t F_OR  = 4'b0001;
  localparam func_t F_ADD = 4'b0010;
  localparam func_t F_SUB = 4'b0110;
  localparam func_t F_SLT = 4'b0111;
  localparam func_t F_NOR = 4'b1100;
endpackage

interface alu_arbiter_if #(
  parameter int NREQ = 2
);
  import alu_pkg::*;

  logic  [NREQ-1:0]        req_valid;
  logic  [NREQ-1:0]        req_ready;
  func_t [NREQ-1:0]        req_func;
  word_t [NREQ-1:0]        req_a;
  word_t [NREQ-1:0]        req_b;
  logic  [NREQ-1:0]        rsp_valid;
  logic  [NREQ-1:0]        rsp_ready;
  word_t                   rsp_result;
  logic                    rsp_zero;

  modport master (
    output req_valid, req_func, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, req_func, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered alu among NREQ requesters.
// Define ALU_ARB_PERF_EN to add saturating per-requester grant counters.
module alu
  import alu_pkg::*;
(
  input  func_t func,
  input  word_t a,
  input  word_t b,
  output word_t result,
  output logic  zero
);
  always_comb begin
    result = '0;
    case (func)
      F_AND:   result = a & b;
      F_OR:    result = a | b;
      F_NOR:   result = ~(a | b);
      F_SLT:   result = {31'b0, a < b};
      F_ADD:   result = a + b;
      F_SUB:   result = a - b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
  ,
  input  logic                        perf_clr,
  output logic [NREQ-1:0][CNT_W-1:0]  grant_count
`endif
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   gnt;
  logic            gnt_hit;
  logic            can_accept;
  logic            accept;
  logic            rsp_hs;
  word_t           result_q;
  logic            zero_q;
  word_t           alu_result;
  logic            alu_zero;
  logic [NREQ-1:0] req_ready_d;
  logic [NREQ-1:0] rsp_valid_d;

  // Scan starts just after the last grant, so every requester is
  // reached within NREQ grants.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_hit = 1'b0;
    gnt     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_hit && bus.req_valid[idx]) begin
        gnt_hit = 1'b1;
        gnt     = idx[IW-1:0];
      end
    end
  end

  alu u_alu (
    .func   (bus.req_func[gnt]),
    .a      (bus.req_a[gnt]),
    .b      (bus.req_b[gnt]),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign rsp_hs     = (state == RESP) & bus.rsp_ready[owner];
  assign can_accept = ~rst & ((state == IDLE) | rsp_hs);
  assign accept     = can_accept & gnt_hit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RESP;
      RESP: if (rsp_hs) state_nxt = accept ? RESP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d = '0;
    rsp_valid_d = '0;
    if (accept)         req_ready_d[gnt]   = 1'b1;
    if (state == RESP)  rsp_valid_d[owner] = 1'b1;
  end

  assign bus.req_ready  = req_ready_d;
  assign bus.rsp_valid  = rsp_valid_d;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      owner      <= '0;
      last_grant <= IW'(NREQ - 1);
    end else if (accept) begin
      result_q   <= alu_result;
      zero_q     <= alu_zero;
      owner      <= gnt;
      last_grant <= gnt;
    end
  end

`ifdef ALU_ARB_PERF_EN
  // Clear has priority over a same-cycle grant.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      grant_count <= '0;
    end else if (accept && (grant_count[gnt] != {CNT_W{1'b1}})) begin
      grant_count[gnt] <= grant_count[gnt] + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Table-driven bench for alu_arbiter with a response scoreboard.
// Runs with NREQ=3 so that scan wrap-around is exercised.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 3;

  typedef struct packed {
    logic [2:0]       valid;
    logic [2:0]       rrdy;
    logic [2:0]       exp;
    logic [2:0][3:0]  func;
    logic [2:0][31:0] a;
    logic [2:0][31:0] b;
  } vec_t;

  typedef struct packed {
    logic [1:0]  owner;
    logic [31:0] result;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  vec_t tbl[$];

  alu_arbiter_if #(.NREQ(N)) bus ();

`ifdef ALU_ARB_PERF_EN
  logic                 perf_clr = 1'b0;
  logic [N-1:0][1:0]    grant_count;
`endif

  alu_arbiter #(
    .NREQ  (N),
    .CNT_W (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_clr    (perf_clr),
    .grant_count (grant_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] ref_alu(logic [3:0] f,
                                          logic [31:0] a,
                                          logic [31:0] b);
    logic [31:0] r;
    if (f == F_ADD)      r = a + b;
    else if (f == F_SUB) r = a + ~b + 32'd1;
    else if (f == F_AND) r = a & b;
    else if (f == F_OR)  r = a | b;
    else if (f == F_NOR) r = ~a & ~b;
    else if (f == F_SLT) r = ($unsigned(a) < $unsigned(b)) ? 32'd1 : 32'd0;
    else                 r = 32'd0;
    return {(r == 32'd0), r};
  endfunction

  function automatic vec_t mk(logic [2:0] valid, logic [2:0] rrdy,
                              logic [2:0] exp,
                              logic [3:0] f0, logic [31:0] a0, logic [31:0] b0,
                              logic [3:0] f1, logic [31:0] a1, logic [31:0] b1,
                              logic [3:0] f2, logic [31:0] a2, logic [31:0] b2);
    vec_t v;
    v.valid = valid;
    v.rrdy  = rrdy;
    v.exp   = exp;
    v.func[0] = f0; v.a[0] = a0; v.b[0] = b0;
    v.func[1] = f1; v.a[1] = a1; v.b[1] = b1;
    v.func[2] = f2; v.a[2] = a2; v.b[2] = b2;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.req_valid = v.valid;
    bus.rsp_ready = v.rrdy;
    bus.req_func  = v.func;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
  endtask

  task automatic check(vec_t v, int s);
    logic [32:0] r;
    chk($sformatf("req_ready s%0d", s), 32'(bus.req_ready), 32'(v.exp));
    if (q.size() > 0) begin
      chk($sformatf("rsp_valid s%0d", s), 32'(bus.rsp_valid),
          32'(3'b001 << q[0].owner));
      chk($sformatf("result s%0d", s), bus.rsp_result, q[0].result);
      chk($sformatf("zero s%0d", s), 32'(bus.rsp_zero), 32'(q[0].zero));
      if (v.rrdy[q[0].owner]) void'(q.pop_front());
    end else begin
      chk($sformatf("rsp_idle s%0d", s), 32'(bus.rsp_valid), 32'd0);
    end
    for (int i = 0; i < N; i++) begin
      if (v.exp[i]) begin
        r = ref_alu(v.func[i], v.a[i], v.b[i]);
        q.push_back('{owner: 2'(i), result: r[31:0], zero: r[32]});
      end
    end
  endtask

  task automatic step(vec_t v, logic r, logic pc, int s);
    @(posedge clk);
    #1;
    rst = r;
`ifdef ALU_ARB_PERF_EN
    perf_clr = pc;
`endif
    drive(v);
    @(negedge clk);
    check(v, s);
  endtask

  vec_t vx, vr, vp, vi;

  initial begin
    vi = mk(3'b000, 3'b111, 3'b000, F_ADD, 0, 0, F_ADD, 0, 0, F_ADD, 0, 0);
    vx = mk(3'b111, 3'b111, 3'b001, F_ADD, 10, 20, F_SUB, 1, 2,
            F_AND, 32'hF0F0, 32'hFF);

    // single op, contention, backpressure, wrap, undefined func, rotation
    tbl.push_back(mk(3'b001, 3'b001, 3'b001, F_ADD, 5, 7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b001, 3'b000, F_ADD, 5, 7, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(3'b011, 3'b011, (i % 2) ? 3'b001 : 3'b010,
                       F_SUB, 3, 3, F_SLT, 1, 2, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b011, 3'b010, F_SUB, 3, 3, F_SLT, 1, 2, 0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b011, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b000, 3'b001, F_ADD, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b000, 3'b000, F_ADD, 1, 1,
                     F_AND, 32'hFF, 32'h0F, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b010, 3'b000, F_ADD, 1, 1,
                     F_AND, 32'hFF, 32'h0F, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b000, 3'b000, F_ADD, 1, 1,
                     F_AND, 32'hFF, 32'h0F, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b000, 3'b000, F_ADD, 1, 1,
                     F_AND, 32'hFF, 32'h0F, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b001, 3'b010, F_ADD, 1, 1,
                     F_AND, 32'hFF, 32'h0F, 0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b010, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b100, 3'b100, 3'b100, 0, 0, 0, 0, 0, 0,
                     F_SLT, 32'hFFFF_FFFF, 0));
    tbl.push_back(mk(3'b101, 3'b101, 3'b001, F_NOR, 0, 0, 0, 0, 0,
                     F_OR, 32'hF0, 32'h0F));
    tbl.push_back(mk(3'b100, 3'b101, 3'b100, F_NOR, 0, 0, 0, 0, 0,
                     F_OR, 32'hF0, 32'h0F));
    tbl.push_back(mk(3'b000, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b000, 3'b010, 0, 0, 0, 4'hF, 1, 2, 0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b010, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b111, 3'b111, 3'b100, vx.func[0], vx.a[0], vx.b[0],
                     vx.func[1], vx.a[1], vx.b[1], vx.func[2], vx.a[2], vx.b[2]));
    tbl.push_back(mk(3'b011, 3'b111, 3'b001, vx.func[0], vx.a[0], vx.b[0],
                     vx.func[1], vx.a[1], vx.b[1], 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b111, 3'b010, 0, 0, 0,
                     vx.func[1], vx.a[1], vx.b[1], 0, 0, 0));
    tbl.push_back(vi);

    // reset state
    vr = vx;
    vr.rrdy = 3'b000;
    vr.exp  = 3'b000;
    drive(vr);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst result", bus.rsp_result, 32'd0);
    chk("rst zero", 32'(bus.rsp_zero), 32'd0);
`ifdef ALU_ARB_PERF_EN
    chk("rst count", 32'(grant_count), 32'd0);
`endif

    foreach (tbl[i]) step(tbl[i], 1'b0, 1'b0, i);

    // reset while a response is pending
    step(mk(3'b010, 3'b000, 3'b010, 0, 0, 0, F_OR, 32'hF0, 32'h0F, 0, 0, 0),
         1'b0, 1'b0, 100);
    step(vr, 1'b1, 1'b0, 101);
    q.delete();
    step(vr, 1'b1, 1'b0, 102);
    chk("midrst result", bus.rsp_result, 32'd0);
    chk("midrst zero", 32'(bus.rsp_zero), 32'd0);
    step(vx, 1'b0, 1'b0, 103);
    vp = vx;
    vp.valid = 3'b110;
    vp.exp   = 3'b010;
    step(vp, 1'b0, 1'b0, 104);
    vp.valid = 3'b100;
    vp.exp   = 3'b100;
    step(vp, 1'b0, 1'b0, 105);
    step(vi, 1'b0, 1'b0, 106);

    // req1 back-to-back, then a clear coinciding with a grant
    vp = mk(3'b010, 3'b111, 3'b010, 0, 0, 0, F_ADD, 2, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(vp, 1'b0, 1'b0, 200 + i);
    step(vp, 1'b0, 1'b1, 205);
`ifdef ALU_ARB_PERF_EN
    chk("count0 pre", 32'(grant_count[0]), 32'd1);
    chk("count1 sat", 32'(grant_count[1]), 32'd3);
    chk("count2 pre", 32'(grant_count[2]), 32'd1);
`endif
    step(vi, 1'b0, 1'b0, 206);
`ifdef ALU_ARB_PERF_EN
    chk("count clr", 32'(grant_count), 32'd0);
`endif
    chk("sb empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
